// File: rtl/cache_pkg.sv
// Shared definitions for the data-side line buffer: geometry, FSM states and
// the word-into-line merge used by every store.
package cache_pkg;

  localparam int LINE_BYTES     = 64;
  localparam int WORD_BYTES     = 8;
  localparam int WORDS_PER_LINE = 8;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} dline_state_t;

  function automatic logic [511:0] line_merge(input logic [511:0] line,
                                              input logic [2:0]   word,
                                              input logic [63:0]  data);
    logic [511:0] merged;
    merged = line;
    merged[{word, 6'b0} +: 64] = data;
    return merged;
  endfunction

endpackage

// File: rtl/dline_store.sv
// Valid / tag / data arrays of the line buffer: one combinational read port,
// one clocked write port, and valid bits that clear asynchronously on reset.
module dline_store #(
  parameter int LINES = 16,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = 58 - IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_index,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [511:0]     rd_line,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [511:0]     wr_line
);

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags  [LINES];
  logic [511:0]     lines [LINES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      valid <= '0;
    else if (wr_en)
      valid[wr_index] <= 1'b1;
  end

  // Tag and data need no reset: a line is only ever read under its valid bit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index]  <= wr_tag;
      lines[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_line  = lines[rd_index];

endmodule

// File: rtl/dline_buffer.sv
// Write-through direct-mapped line buffer between the MEM-stage word port and
// the arbiter's 512-bit line port.
module dline_buffer import cache_pkg::*; #(
  parameter int LINES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         wenable,
  input  logic [63:0]  addr,
  input  logic [63:0]  wdata,
  output logic [63:0]  rdata,
  output logic         done,
  output logic         drequest,
  output logic         dwrenable,
  output logic [63:0]  daddr,
  input  logic [511:0] drdata,
  output logic [511:0] dwdata,
  input  logic         ddone
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 58 - IDX_W;

  dline_state_t state, state_next;

  logic         hit_q;
  logic [63:0]  req_addr;
  logic         req_wen;
  logic [63:0]  req_wdata;

  logic         accept;
  logic         xfer_done;
  logic [63:0]  lookup_addr;
  logic [2:0]   word;
  logic         hit;
  logic         rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [511:0] rd_line;
  logic [511:0] merged;
  logic         wr_en;
  logic [511:0] wr_line;
  logic         unused_ok;

  assign accept      = (state == IDLE) && enable && !hit_q;
  assign xfer_done   = drequest && ddone;
  // While a request is in flight the array is looked up with the latched address.
  assign lookup_addr = ((state == IDLE) && !hit_q) ? addr : req_addr;
  assign word        = lookup_addr[5:3];
  assign hit         = rd_valid && (rd_tag == lookup_addr[63:6+IDX_W]);
  assign unused_ok   = ^{addr[2:0], req_addr[2:0]};

  dline_store #(.LINES(LINES)) store (
    .clk      (clk),
    .reset    (reset),
    .rd_index (lookup_addr[6 +: IDX_W]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (wr_en),
    .wr_index (lookup_addr[6 +: IDX_W]),
    .wr_tag   (lookup_addr[63:6+IDX_W]),
    .wr_line  (wr_line)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && (!hit || wenable)) state_next = hit ? WRITE : FILL;
      FILL:    if (xfer_done) state_next = req_wen ? WRITE : RESP;
      WRITE:   if (xfer_done) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    merged  = line_merge((state == FILL) ? drdata : rd_line, word,
                         (state == IDLE) ? wdata : req_wdata);
    wr_en   = (accept && hit && wenable) || ((state == FILL) && xfer_done);
    wr_line = ((state == FILL) && !req_wen) ? drdata : merged;
    done    = hit_q || (state == RESP);
    rdata   = (done && !req_wen) ? rd_line[{word, 6'b0} +: 64] : 64'd0;
  end

  // A store miss drops drequest for one cycle between the fill and the write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q     <= 1'b0;
      req_addr  <= '0;
      req_wen   <= 1'b0;
      req_wdata <= '0;
      drequest  <= 1'b0;
      dwrenable <= 1'b0;
      daddr     <= '0;
      dwdata    <= '0;
    end else begin
      hit_q <= accept && hit && !wenable;
      if (accept) begin
        req_addr  <= addr;
        req_wen   <= wenable;
        req_wdata <= wdata;
      end
      case (state)
        IDLE: begin
          if (accept && !hit) begin
            drequest  <= 1'b1;
            dwrenable <= 1'b0;
            daddr     <= {addr[63:6], 6'b0};
          end else if (accept && wenable) begin
            drequest  <= 1'b1;
            dwrenable <= 1'b1;
            daddr     <= {addr[63:6], 6'b0};
            dwdata    <= merged;
          end
        end
        FILL: begin
          if (xfer_done) begin
            drequest <= 1'b0;
            if (req_wen) begin
              dwrenable <= 1'b1;
              dwdata    <= merged;
            end
          end
        end
        WRITE: begin
          if (xfer_done)
            drequest <= 1'b0;
          else if (!drequest)
            drequest <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dline_buffer.md
# dline_buffer

- Write-through, direct-mapped line buffer between the core's MEM stage and the memory arbiter's data port.
- Downstream, it is the responder for the MEM-stage 64-bit word request protocol (enable / wenable / addr / rdata / wdata / done).
- Upstream, it is the initiator of 512-bit line transfers on the arbiter's data-side request / done interface.
- It serves read hits in one cycle, fills lines on misses, and writes every store through as a full merged line.

## Interface
- LINES, 16: number of 64-byte lines; power of two, at least 2.
- clk  in  1  core clock; all state updates on the posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  word request valid; held high by the requester until done.
- wenable  in  1  1 = store, 0 = load; stable while enable is high.
- addr  in  64  byte address; bits [2:0] are ignored (8-byte word access).
- wdata  in  64  store data; stable while enable is high.
- rdata  out  64  load data; valid only in the done cycle; 0 otherwise.
- done  out  1  one-cycle completion pulse.
- drequest  out  1  line request to the arbiter; held until ddone.
- dwrenable  out  1  1 = line write, 0 = line read; stable with drequest.
- daddr  out  64  line address, with bits [5:0] = 0.
- drdata  in  512  fill data; valid in the ddone cycle.
- dwdata  out  512  write-through line data.
- ddone  in  1  one-cycle completion pulse from the arbiter.

## Operation
- Address fields: word = addr[5:3]; index = addr[5+log2(LINES):6]; tag = addr[63:6+log2(LINES)].
- Word w of a line occupies bits [64w+63:64w]. Byte 0 of the line sits in bits [7:0].
- Per line, the block stores a valid bit, the tag, and 512 bits of data. There are no dirty bits, because every store is written through.
- State machine: IDLE, FILL, WRITE, RESP.
- IDLE, request with enable=1:
  - Load hit: drive rdata and done. Stay in IDLE.
  - Load miss: go to FILL.
  - Store hit: merge wdata into the stored line, latch the merged line into dwdata, go to WRITE.
  - Store miss: go to FILL.
- FILL: drequest=1, dwrenable=0, daddr = {addr[63:6], 6'b0}.
  - On ddone: install drdata, set valid, write the tag.
  - After a load, go to RESP.
  - After a store, merge wdata into the filled line, latch the merged line into dwdata, go to WRITE.
- WRITE: drequest=1, dwrenable=1.
  - On ddone: go to RESP. The stored line already holds the merged data.
- RESP: done=1. For a load, rdata = the addressed word of the filled line. Return to IDLE.
- Stores also return done; rdata is 0 in a store's done cycle.
- The requester lowers enable in the cycle after done. The block ignores enable in the cycle after done and in RESP, so one request never completes twice.
- If enable drops during FILL or WRITE, the upstream transfer still completes and done still pulses.
- A miss replaces the indexed line unconditionally. No write-back is needed.

## Timing
- Reset values:
  - rdata=0, done=0, drequest=0, dwrenable=0, daddr=0, dwdata=0.
  - state=IDLE; all valid bits 0.
- Reset asserted mid-FILL or mid-WRITE:
  - drequest drops immediately (asynchronous) and the line is not installed.
  - A ddone that arrives later is ignored.
- Load hit: enable sampled at edge N, done=1 during cycle N+1.
- Load miss: drequest rises in the cycle after enable is sampled. done comes 1 cycle after ddone.
- Store hit: WRITE starts 1 cycle after enable is sampled. done comes 1 cycle after ddone.
- Store miss: fill, then write-through. done comes 1 cycle after the second ddone.
- drequest, dwrenable, daddr and dwdata are registered and stay constant until ddone is sampled. drequest is low in the cycle after ddone.
- A ddone sampled while drequest=0 is ignored.
- Back-to-back load hits: at most one per 2 cycles, because of the dead cycle after done.

## Structure
- Shared package `cache_pkg` holds:
  - LINE_BYTES=64, WORD_BYTES=8, WORDS_PER_LINE=8.
  - The state enum dline_state_t {IDLE, FILL, WRITE, RESP}.
  - A function line_merge(line, word, data) that returns the merged 512-bit line.
- One sub-module, `dline_store`: the valid / tag / data arrays.
  - One combinational read port, addressed by index.
  - One write port, written on the posedge.
  - An asynchronous clear of the valid bits.

## Test plan
- Cold load: addr=0x1008, drdata word1=0xDEADBEEF after 3 cycles.
  - Expect one read drequest with daddr=0x1000.
  - Expect done with rdata=0xDEADBEEF, one cycle after ddone.
- Load hit: repeat addr=0x1008 -> done at N+1 with rdata=0xDEADBEEF and no drequest.
- Store hit: addr=0x1010, wdata=0x55.
  - Expect dwrenable=1, daddr=0x1000, dwdata word2=0x55, all other words unchanged.
  - A following load of 0x1010 hits and returns 0x55.
- Store miss: addr=0x2000 (LINES=16).
  - Expect a read transfer, then a write transfer.
  - dwdata word0=wdata; the other words equal drdata.
  - done follows the second ddone.
- Conflict eviction: load 0x1000, then load 0x1400 (same index, different tag).
  - Expect a miss fill for 0x1400.
  - A reload of 0x1000 misses again.
- Reset during FILL: assert reset for 1 cycle before ddone.
  - drequest drops asynchronously, no done pulses, and the line stays invalid.
  - A late ddone is ignored.
